// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back data select and a retired-instruction counter.
// Optional macro WB_SUBWORD_LOAD_EN enables lb/lbu/lh/lhu extraction; otherwise loads pass the raw word.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_regwrite,
    input  logic [1:0]            mem_memtoreg,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_alu_result,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic [DATA_WIDTH-1:0] mem_pc_plus4,
    input  logic [2:0]            mem_funct3,
    output logic                  wb_wen,
    output logic [ADDR_WIDTH-1:0] wb_writereg,
    output logic [DATA_WIDTH-1:0] wb_writedata,
    output logic                  wb_valid,
    output logic [31:0]           retire_count
);

    logic                  q_valid;
    logic                  q_regwrite;
    logic [1:0]            q_memtoreg;
    logic [ADDR_WIDTH-1:0] q_rd;
    logic [DATA_WIDTH-1:0] q_alu;
    logic [DATA_WIDTH-1:0] q_readdata;
    logic [DATA_WIDTH-1:0] q_pc4;
    logic [31:0]           retire_q;
    logic [DATA_WIDTH-1:0] load_data;

`ifdef WB_SUBWORD_LOAD_EN
    logic [2:0]            q_funct3;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
`else
    logic                  unused_funct3;
    assign unused_funct3 = ^mem_funct3;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid    <= 1'b0;
            q_regwrite <= 1'b0;
            q_memtoreg <= '0;
            q_rd       <= '0;
            q_alu      <= '0;
            q_readdata <= '0;
            q_pc4      <= '0;
`ifdef WB_SUBWORD_LOAD_EN
            q_funct3   <= '0;
`endif
        end else if (flush) begin
            // only the control bits matter for a bubble; data fields are left as-is
            q_valid    <= 1'b0;
            q_regwrite <= 1'b0;
        end else if (!stall) begin
            q_valid    <= mem_valid;
            q_regwrite <= mem_regwrite;
            q_memtoreg <= mem_memtoreg;
            q_rd       <= mem_rd;
            q_alu      <= mem_alu_result;
            q_readdata <= mem_readdata;
            q_pc4      <= mem_pc_plus4;
`ifdef WB_SUBWORD_LOAD_EN
            q_funct3   <= mem_funct3;
`endif
        end
    end

    // an instruction retires when it leaves WB, i.e. WB is valid and not held
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
        end else if (q_valid && !stall) begin
            retire_q <= retire_q + 32'd1;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    always_comb begin
        ld_byte   = q_readdata[{q_alu[1:0], 3'b000} +: 8];
        ld_half   = q_readdata[{q_alu[1], 4'b0000} +: 16];
        load_data = q_readdata;
        case (q_funct3)
            3'b000:  load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: load_data = q_readdata;
        endcase
    end
`else
    assign load_data = q_readdata;
`endif

    always_comb begin
        wb_writedata = q_alu;
        case (q_memtoreg)
            2'b01:   wb_writedata = load_data;
            2'b10:   wb_writedata = q_pc4;
            default: wb_writedata = q_alu;
        endcase
    end

    assign wb_wen       = q_valid && q_regwrite && (q_rd != '0);
    assign wb_writereg  = q_rd;
    assign wb_valid     = q_valid;
    assign retire_count = retire_q;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 stall  input  1  hold MEM/WB register contents.
REQ-006 flush  input  1  replace captured instruction with a bubble.
REQ-007 mem_valid  input  1  MEM stage holds a real instruction.
REQ-008 mem_regwrite  input  1  instruction writes rd.
REQ-009 mem_memtoreg  input  2  source select: 00 ALU, 01 load data, 10 pc+4, 11 ALU.
REQ-010 mem_rd  input  ADDR_WIDTH  destination register index.
REQ-011 mem_alu_result  input  DATA_WIDTH  ALU result / load address.
REQ-012 mem_readdata  input  DATA_WIDTH  raw aligned word from data memory.
REQ-013 mem_pc_plus4  input  DATA_WIDTH  link value for jal/jalr.
REQ-014 mem_funct3  input  3  load size/sign code.
REQ-015 wb_wen  output  1  register file write enable.
REQ-016 wb_writereg  output  ADDR_WIDTH  register file write index.
REQ-017 wb_writedata  output  DATA_WIDTH  register file write data.
REQ-018 wb_valid  output  1  WB stage holds a real instruction.
REQ-019 retire_count  output  32  retired-instruction counter.

Function
REQ-020 MEM/WB register captures all mem_* inputs on rising edge; update priority reset > flush > stall > capture.
REQ-021 flush=1: stored valid and regwrite cleared to 0, other fields don't-care; flush overrides stall.
REQ-022 stall=1 (no flush): all stored fields unchanged.
REQ-023 wb_wen = stored valid AND stored regwrite AND stored rd != 0; combinational from register, zero added latency.
REQ-024 wb_writereg = stored rd; wb_valid = stored valid.
REQ-025 wb_writedata combinational from stored fields: 00/11 ALU result, 01 extracted load data, 10 pc+4.
REQ-026 Latency: mem_* presented at edge N visible on wb_* after edge N; register file commits at following falling edge, so an ID read in same cycle sees it.
REQ-027 During stall with wb_wen=1, repeated identical write permitted (idempotent).
REQ-028 retire_count increments by 1 at rising edge when wb_valid=1 and stall=0 (instruction leaves WB); wraps 0xFFFFFFFF -> 0.
REQ-029 Load extraction, offset = stored ALU result[1:0]: funct3 010 full word; other unlisted codes full word.

Reset
REQ-030 reset=1 at rising edge: stored valid, regwrite, rd, memtoreg, all data fields -> 0; retire_count -> 0.
REQ-031 After reset: wb_wen=0, wb_valid=0, wb_writereg=0, wb_writedata=0; reset mid-stall or mid-flush discards held instruction.

Configuration
REQ-032 Macro WB_SUBWORD_LOAD_EN defined: funct3 000 lb (byte at offset, sign-extended), 100 lbu (zero-extended), 001 lh (half at offset[1], sign-extended, offset[0] ignored), 101 lhu (zero-extended).
REQ-033 WB_SUBWORD_LOAD_EN undefined: funct3 ignored, load data = mem_readdata unmodified; no extraction logic synthesized.

Verification
REQ-034 ALU write: valid=1, regwrite=1, memtoreg=00, rd=5, alu=0x00001234 -> next cycle wb_wen=1, writereg=5, writedata=0x00001234; retire_count 0 -> 1 one edge later.
REQ-035 x0 suppression: rd=0, regwrite=1, valid=1 -> wb_wen=0, wb_valid=1, retire_count still increments.
REQ-036 Sub-word (macro on): readdata=0x80FF7F01, alu[1:0]=2, funct3=000 -> writedata=0xFFFFFFFF; funct3=100 -> 0x000000FF; alu[1:0]=2, funct3=001 -> 0xFFFF80FF; macro off, same stimulus -> 0x80FF7F01.
REQ-037 Stall/flush: capture rd=7, assert stall 3 cycles with new mem_* -> wb_* unchanged, retire_count unchanged; stall+flush together -> wb_valid=0, wb_wen=0 next cycle.
REQ-038 Wrap and reset: force retire_count to 0xFFFFFFFF, retire one -> 0x00000000; assert reset during valid write -> all outputs 0 next cycle.
